// File: rtl/ddr_align_checker_if.sv
// Capture-side bus of the DDR training-pattern checker: captured words,
// controller blanking inputs and the alignment report returned to the controller.
interface ddr_align_checker_if #(
    parameter int DW    = 8,
    parameter int OFS_W = 3
);
    logic             lock;
    logic [DW-1:0]    rx_data;
    logic             rx_valid;
    logic             stop;
    logic             datapath_rst;
    logic [1:0]       align_status;
    logic             status_valid;
    logic [OFS_W-1:0] rot_offset;
    logic [7:0]       err_cnt;

    modport master (
        output lock, rx_data, rx_valid, stop, datapath_rst,
        input  align_status, status_valid, rot_offset, err_cnt
    );

    modport slave (
        input  lock, rx_data, rx_valid, stop, datapath_rst,
        output align_status, status_valid, rot_offset, err_cnt
    );
endinterface

// File: rtl/ddr_align_checker.sv
// Checks captured read words against a rotating training pattern over fixed
// windows and reports bit-sampling / word-alignment health to the phase controller.
module ddr_align_checker #(
    parameter int          DW      = 8,
    parameter logic [DW-1:0] PATTERN = 8'hF0,
    parameter int          WIN     = 16,
    parameter int          CNT_W   = 5,
    parameter int          OFS_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    ddr_align_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        EVAL   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             lock_reg;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    prev;
    logic [OFS_W-1:0] win_ofs;
    logic             bit_sticky;
    logic             hit;
    logic [OFS_W-1:0] ofs;
    logic             accept;
    logic             report;
    logic             blank;

    function automatic logic [DW-1:0] rotl(input int unsigned k);
        logic [2*DW-1:0] pp;
        pp = {PATTERN, PATTERN} << k;
        return pp[2*DW-1:DW];
    endfunction

    // Smallest matching rotation wins.
    always_comb begin
        hit = 1'b0;
        ofs = '0;
        for (int unsigned k = 0; k < DW; k++) begin
            if (!hit && bus.rx_data == rotl(k)) begin
                hit = 1'b1;
                ofs = OFS_W'(k);
            end
        end
    end

    assign blank = bus.stop | bus.datapath_rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Lock loss overrides everything, including a pending REPORT.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        report  = 1'b0;
        if (!lock_reg) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (!blank) state_d = FIRST;
                FIRST: begin
                    if (blank) state_d = IDLE;
                    else if (bus.rx_valid) begin
                        accept  = 1'b1;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    if (blank) state_d = IDLE;
                    else if (bus.rx_valid) begin
                        accept = 1'b1;
                        if (cnt == CNT_W'(WIN - 1)) state_d = REPORT;
                    end
                end
                REPORT: begin
                    report  = 1'b1;
                    state_d = blank ? IDLE : FIRST;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_reg         <= 1'b0;
            cnt              <= '0;
            prev             <= '0;
            win_ofs          <= '0;
            bit_sticky       <= 1'b0;
            bus.align_status <= 2'b11;
            bus.status_valid <= 1'b0;
            bus.rot_offset   <= '0;
            bus.err_cnt      <= '0;
        end else begin
            lock_reg         <= bus.lock;
            bus.status_valid <= report;
            if (!lock_reg) begin
                bus.align_status <= 2'b11;
                cnt              <= '0;
                bit_sticky       <= 1'b0;
            end else if (accept) begin
                prev <= bus.rx_data;
                if (state_q == FIRST) begin
                    win_ofs    <= ofs;
                    bit_sticky <= ~hit;
                    cnt        <= CNT_W'(1);
                end else begin
                    bit_sticky <= bit_sticky | ~hit | (bus.rx_data != prev);
                    cnt        <= cnt + 1'b1;
                end
            end
            if (report) begin
                bus.align_status <= {bit_sticky | (win_ofs != '0), bit_sticky};
                if (!bit_sticky) bus.rot_offset <= win_ofs;
                if (bit_sticky && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 1'b1;
            end
        end
    end

endmodule
